if_fetch_unit: RTL and testbench

- Instruction-fetch stage for the 5-stage LEGv8 pipelined CPU. It sits directly upstream of the decode stage.
- Owns the PC register and drives a request/response port to instruction memory.
- Applies branch redirects from the later stages, and presents the IF/ID pipeline register (instr, pc, valid) to decode.
- Honours decode stalls without losing a returned instruction, and discards stale responses after a redirect.

---
 rtl/if_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to
// instruction memory, and presents the IF/ID register (instr, pc, valid) to
// decode. A one-entry skid buffer catches a response that arrives while decode
// is stalled. Redirects flush IF/ID and drain any stale outstanding request.
module if_fetch_unit #(
  parameter int unsigned     PC_W     = 64,
  parameter int unsigned     INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h0)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_id,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_id,
  output logic [PC_W-1:0]    pc_id,
  output logic               valid_id
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(64'd4);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               req_q, req_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_id_q, pc_id_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;

  logic               accept_s;
  logic               deliverable_s;
  logic [PC_W-1:0]    redirect_tgt_s;

  // req_q is only ever set while in FETCH; after reset it stays low for one
  // cycle so no request is presented while reset is asserted.
  assign accept_s       = req_q & imem_ready;
  assign deliverable_s  = ~valid_q | ~stall_id;
  assign redirect_tgt_s = {redirect_pc[PC_W-1:2], 2'b00};

  // Next-state, PC, IF/ID and skid computation; redirect overrides everything.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_id_d      = pc_id_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    req_d        = 1'b0;

    // Decode takes the presented instruction; a load below may refill it.
    if (valid_q && !stall_id) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      ST_FETCH: begin
        if (accept_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          pc_d = pc_q + PC_STEP;
          if (deliverable_s) begin
            instr_d = imem_rdata;
            pc_id_d = pc_q;
            valid_d = 1'b1;
            state_d = ST_FETCH;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = ST_HOLD;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (!stall_id) begin
          instr_d = skid_instr_q;
          pc_id_d = skid_pc_q;
          valid_d = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (imem_rvalid) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if (redirect_valid) begin
      pc_d         = redirect_tgt_s;
      valid_d      = 1'b0;
      instr_d      = instr_q;
      pc_id_d      = pc_id_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      case (state_q)
        ST_FETCH: state_d = accept_s ? ST_DRAIN : ST_FETCH;
        ST_WAIT:  state_d = imem_rvalid ? ST_FETCH : ST_DRAIN;
        ST_HOLD:  state_d = ST_FETCH;
        ST_DRAIN: state_d = imem_rvalid ? ST_FETCH : ST_DRAIN;
        default:  state_d = ST_FETCH;
      endcase
    end else begin
      state_d = state_d;
    end

    req_d = (state_d == ST_FETCH);
  end

  // State, PC, IF/ID and skid registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      instr_q      <= {INSTR_W{1'b0}};
      pc_id_q      <= {PC_W{1'b0}};
      valid_q      <= 1'b0;
      skid_instr_q <= {INSTR_W{1'b0}};
      skid_pc_q    <= {PC_W{1'b0}};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      instr_q      <= instr_d;
      pc_id_q      <= pc_id_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign instr_id  = instr_q;
  assign pc_id     = pc_id_q;
  assign valid_id  = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by randomized traffic
// checked against an in-order instruction-stream model of the fetch stage.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall_id;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_id;
  logic [63:0] pc_id;
  logic        valid_id;

  int checks;
  int errors;

  if_fetch_unit #(.PC_W(64), .INSTR_W(32), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .stall_id(stall_id),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_id(instr_id), .pc_id(pc_id), .valid_id(valid_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[33:2];
    return (lo * 32'h9E37_79B1) ^ {2'b00, a[63:34]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_req();
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    imem_rvalid = 1'b1;
    imem_rdata  = d;
    step();
    imem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b expected 0", imem_req); end
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid_id); end
    checks++; if (instr_id !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr_id); end
    checks++; if (pc_id !== 64'h0) begin errors++; $display("FAIL reset_pc_id: got %h expected 0", pc_id); end
    checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    reset = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL release_req: got %0b expected 1", imem_req); end
  endtask

  task automatic test_seq_fetch();
    checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL seq_addr0: got %h expected 0", imem_addr); end
    accept_req();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_wait_req: got %0b expected 0", imem_req); end
    respond(32'h8B02_0020);
    checks++; if (valid_id !== 1'b1) begin errors++; $display("FAIL seq_valid0: got %0b expected 1", valid_id); end
    checks++; if (pc_id !== 64'h0) begin errors++; $display("FAIL seq_pc0: got %h expected 0", pc_id); end
    checks++; if (instr_id !== 32'h8B02_0020) begin errors++; $display("FAIL seq_instr0: got %h expected 8b020020", instr_id); end
    checks++; if (imem_addr !== 64'h4) begin errors++; $display("FAIL seq_addr4: got %h expected 4", imem_addr); end
    accept_req();
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL seq_consumed: got %0b expected 0", valid_id); end
    respond(32'h8B03_0041);
    checks++; if (pc_id !== 64'h4) begin errors++; $display("FAIL seq_pc4: got %h expected 4", pc_id); end
    checks++; if (instr_id !== 32'h8B03_0041) begin errors++; $display("FAIL seq_instr4: got %h expected 8b030041", instr_id); end
    checks++; if (valid_id !== 1'b1) begin errors++; $display("FAIL seq_valid4: got %0b expected 1", valid_id); end
    checks++; if (imem_addr !== 64'h8) begin errors++; $display("FAIL seq_addr8: got %h expected 8", imem_addr); end
  endtask

  task automatic test_stall_skid();
    stall_id = 1'b1;
    accept_req();
    checks++; if (pc_id !== 64'h4 || valid_id !== 1'b1) begin errors++; $display("FAIL skid_hold1: got pc %h v %0b expected 4/1", pc_id, valid_id); end
    respond(32'hF800_0000);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL skid_req: got %0b expected 0", imem_req); end
    checks++; if (pc_id !== 64'h4 || valid_id !== 1'b1) begin errors++; $display("FAIL skid_hold2: got pc %h v %0b expected 4/1", pc_id, valid_id); end
    step();
    checks++; if (pc_id !== 64'h4 || imem_req !== 1'b0) begin errors++; $display("FAIL skid_hold3: got pc %h req %0b expected 4/0", pc_id, imem_req); end
    stall_id = 1'b0;
    step();
    checks++; if (pc_id !== 64'h8) begin errors++; $display("FAIL skid_pc: got %h expected 8", pc_id); end
    checks++; if (instr_id !== 32'hF800_0000) begin errors++; $display("FAIL skid_instr: got %h expected f8000000", instr_id); end
    checks++; if (valid_id !== 1'b1) begin errors++; $display("FAIL skid_valid: got %0b expected 1", valid_id); end
    checks++; if (imem_addr !== 64'hC || imem_req !== 1'b1) begin errors++; $display("FAIL skid_next: got addr %h req %0b expected c/1", imem_addr, imem_req); end
  endtask

  task automatic test_redirect_wait();
    accept_req();
    respond(32'h1111_000C);
    checks++; if (pc_id !== 64'hC || imem_addr !== 64'h10) begin errors++; $display("FAIL rdw_setup: got pc %h addr %h expected c/10", pc_id, imem_addr); end
    accept_req();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h103;
    step();
    redirect_valid = 1'b0;
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL rdw_valid: got %0b expected 0", valid_id); end
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdw_drain_req: got %0b expected 0", imem_req); end
    respond(32'hDEAD_BEEF);
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL rdw_stale: got %0b expected 0", valid_id); end
    checks++; if (instr_id !== 32'h1111_000C) begin errors++; $display("FAIL rdw_instr: got %h expected 1111000c", instr_id); end
    checks++; if (imem_addr !== 64'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL rdw_addr: got %h req %0b expected 100/1", imem_addr, imem_req); end
  endtask

  task automatic test_redirect_coincident();
    accept_req();
    respond(32'h0000_0100);
    stall_id = 1'b1;
    accept_req();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h40;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'h1111_1111;
    step();
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b0;
    stall_id       = 1'b0;
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL rc_valid: got %0b expected 0", valid_id); end
    checks++; if (pc_id !== 64'h100) begin errors++; $display("FAIL rc_pc_hold: got %h expected 100", pc_id); end
    checks++; if (imem_addr !== 64'h40 || imem_req !== 1'b1) begin errors++; $display("FAIL rc_addr: got %h req %0b expected 40/1", imem_addr, imem_req); end
    accept_req();
    respond(32'h2222_2222);
    checks++; if (pc_id !== 64'h40 || instr_id !== 32'h2222_2222) begin errors++; $display("FAIL rc_next: got pc %h instr %h expected 40/22222222", pc_id, instr_id); end
  endtask

  task automatic test_backpressure_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL bp_hold: got req %0b addr %h expected 1/fffffffffffffffc", imem_req, imem_addr); end
    end
    accept_req();
    respond(32'hAAAA_5555);
    checks++; if (pc_id !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_pc_id: got %h expected fffffffffffffffc", pc_id); end
    checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 0", imem_addr); end
  endtask

  task automatic test_async_reset();
    accept_req();
    respond(32'h1234_5678);
    stall_id = 1'b1;
    accept_req();
    checks++; if (valid_id !== 1'b1 || imem_addr !== 64'h4) begin errors++; $display("FAIL ar_setup: got v %0b addr %h expected 1/4", valid_id, imem_addr); end
    reset = 1'b0;
    #1;
    checks++; if (valid_id !== 1'b0 || instr_id !== 32'h0 || pc_id !== 64'h0) begin errors++; $display("FAIL ar_clear: got v %0b instr %h pc %h expected 0/0/0", valid_id, instr_id, pc_id); end
    checks++; if (imem_req !== 1'b0 || imem_addr !== 64'h0) begin errors++; $display("FAIL ar_req: got req %0b addr %h expected 0/0", imem_req, imem_addr); end
    @(posedge clk);
    #1;
    reset       = 1'b1;
    stall_id    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    step();
    imem_rvalid = 1'b0;
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL ar_ignore: got %0b expected 0", valid_id); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin errors++; $display("FAIL ar_restart: got req %0b addr %h expected 1/0", imem_req, imem_addr); end
    accept_req();
    respond(32'h8B02_0020);
    checks++; if (pc_id !== 64'h0 || instr_id !== 32'h8B02_0020 || valid_id !== 1'b1) begin errors++; $display("FAIL ar_refetch: got pc %h instr %h v %0b expected 0/8b020020/1", pc_id, instr_id, valid_id); end
  endtask

  // Random traffic: the delivered stream must be consecutive words from the
  // last redirect target, each carrying the memory word at its address.
  task automatic test_random();
    logic [63:0] exp_pc;
    logic [63:0] p_pc;
    logic [31:0] p_instr;
    logic        p_valid;
    logic        mem_busy;
    logic [63:0] mem_addr;
    int          mem_wait;
    int          delivered;
    exp_pc    = 64'h4;
    mem_busy  = 1'b0;
    mem_addr  = 64'h0;
    mem_wait  = 0;
    delivered = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      p_valid        = valid_id;
      p_pc           = pc_id;
      p_instr        = instr_id;
      stall_id       = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = {$urandom(), $urandom()};
      imem_ready     = ($urandom_range(0, 2) != 0);
      imem_rvalid    = 1'b0;
      if (mem_busy) begin
        if (mem_wait == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(mem_addr);
          mem_busy    = 1'b0;
        end else begin
          mem_wait--;
        end
      end else if (imem_req && imem_ready) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_wait = $urandom_range(0, 3);
      end
      step();
      if (redirect_valid) begin
        exp_pc = {redirect_pc[63:2], 2'b00};
        checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL rnd_flush: got %0b expected 0 cyc %0d", valid_id, cyc); end
      end else if (p_valid && stall_id) begin
        checks++; if (valid_id !== 1'b1 || pc_id !== p_pc || instr_id !== p_instr) begin errors++; $display("FAIL rnd_hold: got v %0b pc %h instr %h expected 1/%h/%h cyc %0d", valid_id, pc_id, instr_id, p_pc, p_instr, cyc); end
      end else if (valid_id) begin
        checks++; if (pc_id !== exp_pc || instr_id !== mem_word(exp_pc)) begin errors++; $display("FAIL rnd_stream: got pc %h instr %h expected %h/%h cyc %0d", pc_id, instr_id, exp_pc, mem_word(exp_pc), cyc); end
        exp_pc = exp_pc + 64'd4;
        delivered++;
      end
    end
    redirect_valid = 1'b0;
    stall_id       = 1'b0;
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b0;
    checks++; if (delivered < 200) begin errors++; $display("FAIL rnd_progress: got %0d deliveries expected at least 200", delivered); end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b0;
    stall_id       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    test_reset();
    test_seq_fetch();
    test_stall_skid();
    test_redirect_wait();
    test_redirect_coincident();
    test_backpressure_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
